// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the 16-bit memory bus initiator.
// The state enum, default bus widths and reset-value constants live here
// so the master and any bench agree on the encoding.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Out of reset the master sits in IDLE, advertising readiness with all
    // memory strobes, address and data driven low.
    localparam state_t RST_STATE     = IDLE;
    localparam logic   RST_REQ_READY = 1'b1;

endpackage

// File: rtl/mem_bus_master.sv
// Bus initiator for the 16-bit memory port.
// Takes read/write requests on a valid/ready front end, drives address,
// load, out_en and the shared data bus, and returns read data on a
// valid/ready response channel.
// Optional feature: define MEM_MASTER_BURST_EN to add the req_len port and
// multi-beat reads with an auto-incrementing address.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1,
    parameter int BURST_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
`ifdef MEM_MASTER_BURST_EN
    input  logic [BURST_W-1:0] req_len,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_last,
    output logic [ADDR_W-1:0]  address,
    output logic               load,
    output logic               out_en,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_oe,
    input  logic [DATA_W-1:0]  data_in
);

    // Latency counter loads READ_LAT-1 and counts down to zero while out_en
    // is held, so it needs just enough bits for READ_LAT-1.
    localparam int               LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [LAT_W-1:0]  lat_q;
    logic              accept;
    logic              lat_done;
    logic              more_beats;

`ifdef MEM_MASTER_BURST_EN
    logic [BURST_W-1:0] beats_q;
    logic               last_q;

    assign more_beats = (beats_q != '0);
`else
    assign more_beats = 1'b0;
`endif

    assign accept   = req_valid && (state_q == IDLE);
    assign lat_done = (lat_q == '0);

    // State register; asynchronous reset returns to IDLE immediately and
    // discards any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: writes take one WR cycle, reads alternate RD/RSP per beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_write ? WR : RD;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                if (lat_done) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = more_beats ? RD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, latency/beat counters and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lat_q   <= '0;
`ifdef MEM_MASTER_BURST_EN
            beats_q <= '0;
            last_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        lat_q  <= LAT_INIT;
                        // Keep data_out at the last written value across reads.
                        if (req_write) begin
                            wdata_q <= req_wdata;
                        end
`ifdef MEM_MASTER_BURST_EN
                        beats_q <= req_write ? '0 : req_len;
`endif
                    end
                end
                RD: begin
                    if (lat_done) begin
                        rdata_q <= data_in;
`ifdef MEM_MASTER_BURST_EN
                        last_q  <= !more_beats;
`endif
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                RSP: begin
                    // Next beat: address wraps naturally at 2^ADDR_W.
                    if (rsp_ready && more_beats) begin
                        addr_q <= addr_q + 1'b1;
                        lat_q  <= LAT_INIT;
`ifdef MEM_MASTER_BURST_EN
                        beats_q <= beats_q - 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes decode straight from the state, so WR and RD can never overlap
    // and an asynchronous reset clears them without waiting for a clock.
    assign req_ready = (state_q == IDLE) ? RST_REQ_READY : 1'b0;
    assign load      = (state_q == WR);
    assign data_oe   = (state_q == WR);
    assign out_en    = (state_q == RD);
    assign rsp_valid = (state_q == RSP);
    assign address   = addr_q;
    assign data_out  = wdata_q;
    assign rsp_rdata = rdata_q;

`ifdef MEM_MASTER_BURST_EN
    assign rsp_last  = rsp_valid && last_q;
`else
    assign rsp_last  = rsp_valid;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with READ_LAT = 3.
// A transaction-level model (request stream + reference memory) predicts the
// outputs every cycle; directed tests add literal expectations on top.
module tb_mem_bus_master;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;
    localparam int BW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
`ifdef MEM_MASTER_BURST_EN
    logic [BW-1:0] req_len = '0;
`endif
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic [AW-1:0] address;
    logic          load;
    logic          out_en;
    logic [DW-1:0] data_out;
    logic          data_oe;
    logic [DW-1:0] data_in;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .READ_LAT(LAT),
        .BURST_W (BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
`ifdef MEM_MASTER_BURST_EN
        .req_len  (req_len),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_last (rsp_last),
        .address  (address),
        .load     (load),
        .out_en   (out_en),
        .data_out (data_out),
        .data_oe  (data_oe),
        .data_in  (data_in)
    );

    // Memories store value ^ pat(addr), so an untouched location reads pat(addr).
    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    bit [15:0] mem_blk_d [0:65535];   // memory block driven by DUT pins
    bit [15:0] mem_ref_d [0:65535];   // reference memory driven by requests

    assign data_in = out_en ? (mem_blk_d[address] ^ pat(address)) : 16'hDEAD;

    always @(negedge clk) begin
        if (reset && load) mem_blk_d[address] <= data_out ^ pat(address);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: 0 idle, 1 write cycle, 2 read beat.
    int            m_kind = 0;
    int            m_cnt  = 0;
    int            m_beat = 0;
    int            m_len  = 0;
    logic [15:0]   m_addr = '0;
    logic [15:0]   m_data = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_kind <= 0;
            m_cnt  <= 0;
            m_beat <= 0;
            m_len  <= 0;
        end else begin
            case (m_kind)
                0: if (req_valid) begin
                    m_addr <= req_addr;
                    m_beat <= 0;
                    m_cnt  <= 1;
                    if (req_write) begin
                        m_kind <= 1;
                        m_data <= req_wdata;
                        mem_ref_d[req_addr] <= req_wdata ^ pat(req_addr);
                    end else begin
                        m_kind <= 2;
`ifdef MEM_MASTER_BURST_EN
                        m_len  <= int'(req_len);
`else
                        m_len  <= 0;
`endif
                    end
                end
                1: m_kind <= 0;
                default: begin
                    if (m_cnt <= LAT) m_cnt <= m_cnt + 1;
                    else if (rsp_ready) begin
                        if (m_beat < m_len) begin
                            m_beat <= m_beat + 1;
                            m_cnt  <= 1;
                        end else begin
                            m_kind <= 0;
                        end
                    end
                end
            endcase
        end
    end

    // Monitors / logs used by the directed literal checks.
    int          oe_cnt = 0, load_cnt = 0, ovl_cnt = 0, rv_cnt = 0;
    logic        oe_prev = 1'b0;
    logic [15:0] beat_addr_q[$];
    logic [15:0] rsp_data_q[$];
    logic        rsp_last_q[$];

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [15:0] ea;
        ea = m_addr + 16'(m_beat);
        chk("no_oe_overlap", {31'd0, data_oe && out_en}, 32'd0);
        if (!reset) begin
            chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_load", {31'd0, load}, 32'd0);
            chk("rst_out_en", {31'd0, out_en}, 32'd0);
            chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
            chk("rst_address", {16'd0, address}, 32'd0);
            chk("rst_data_out", {16'd0, data_out}, 32'd0);
        end else begin
            case (m_kind)
                0: begin
                    chk("idle_ready", {31'd0, req_ready}, 32'd1);
                    chk("idle_load", {31'd0, load}, 32'd0);
                    chk("idle_out_en", {31'd0, out_en}, 32'd0);
                    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                end
                1: begin
                    chk("wr_ready", {31'd0, req_ready}, 32'd0);
                    chk("wr_load", {31'd0, load}, 32'd1);
                    chk("wr_data_oe", {31'd0, data_oe}, 32'd1);
                    chk("wr_address", {16'd0, address}, {16'd0, m_addr});
                    chk("wr_data_out", {16'd0, data_out}, {16'd0, m_data});
                    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                end
                default: begin
                    chk("rd_ready", {31'd0, req_ready}, 32'd0);
                    if (m_cnt <= LAT) begin
                        chk("rd_out_en", {31'd0, out_en}, 32'd1);
                        chk("rd_address", {16'd0, address}, {16'd0, ea});
                        chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        chk("rsp_out_en", {31'd0, out_en}, 32'd0);
                        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
                        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mem_ref_d[ea] ^ pat(ea)});
                        chk("rsp_last", {31'd0, rsp_last}, {31'd0, m_beat == m_len});
                    end
                end
            endcase
        end
        if (out_en) oe_cnt++;
        if (load) load_cnt++;
        if (rsp_valid) rv_cnt++;
        if (data_oe && out_en) ovl_cnt++;
        if (out_en && !oe_prev) beat_addr_q.push_back(address);
        if (reset && rsp_valid && rsp_ready) begin
            rsp_data_q.push_back(rsp_rdata);
            rsp_last_q.push_back(rsp_last);
        end
        oe_prev = out_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        chk("ready_wait", {31'd0, t < 50}, 32'd1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        wait_ready();
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [15:0] a, input int len);
        wait_ready();
        req_write = 1'b0;
        req_addr  = a;
`ifdef MEM_MASTER_BURST_EN
        req_len   = BW'(len);
`endif
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input int len, input int hold);
        int nb;
        issue_read(a, len);
`ifdef MEM_MASTER_BURST_EN
        nb = len + 1;
`else
        nb = 1;
`endif
        for (int b = 0; b < nb; b++) begin
            int t = 0;
            while (!rsp_valid && t < 50) begin
                tick();
                t++;
            end
            chk("rsp_wait", {31'd0, t < 50}, 32'd1);
            if (t >= 50) return;
            repeat (hold) tick();
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0, oc0, n0, rv0;
        // Reset held low with random inputs.
        for (int i = 0; i < 5; i++) begin
            tick();
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            rsp_ready = 1'($urandom);
`ifdef MEM_MASTER_BURST_EN
            req_len   = BW'($urandom);
`endif
        end
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        reset = 1'b1;
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Write 0xBEEF to 0x1234, accepted on the first cycle after release.
        lc0 = load_cnt;
        do_write(16'h1234, 16'hBEEF);
        chk("first_wr_load", {31'd0, load}, 32'd1);
        chk("first_wr_addr", {16'd0, address}, 32'h1234);
        tick();
        tick();
        chk("wr_load_cycles", load_cnt - lc0, 32'd1);

        do_read(16'h1234, 0, 0);
        chk("rd_beef_data", {16'd0, rsp_data_q[$]}, 32'hBEEF);
        chk("rd_beef_last", {31'd0, rsp_last_q[$]}, 32'd1);

        // Read with rsp_ready held low for 5 cycles.
        oc0 = oe_cnt;
        do_read(16'h0100, 0, 5);
        chk("lat3_oe_cycles", oe_cnt - oc0, 32'd3);
        chk("lat3_data", {16'd0, rsp_data_q[$]}, 32'h5B5A);

`ifdef MEM_MASTER_BURST_EN
        // Burst across the address wrap.
        n0 = beat_addr_q.size();
        rv0 = rsp_data_q.size();
        do_read(16'hFFFE, 3, 1);
        chk("burst_beats", beat_addr_q.size() - n0, 32'd4);
        chk("burst_rsps", rsp_data_q.size() - rv0, 32'd4);
        if (beat_addr_q.size() - n0 == 4 && rsp_data_q.size() - rv0 == 4) begin
            chk("burst_a0", {16'd0, beat_addr_q[n0]},   32'hFFFE);
            chk("burst_a1", {16'd0, beat_addr_q[n0+1]}, 32'hFFFF);
            chk("burst_a2", {16'd0, beat_addr_q[n0+2]}, 32'h0000);
            chk("burst_a3", {16'd0, beat_addr_q[n0+3]}, 32'h0001);
            chk("burst_d0", {16'd0, rsp_data_q[rv0]},   32'hA5A4);
            chk("burst_d2", {16'd0, rsp_data_q[rv0+2]}, 32'h5A5A);
            chk("burst_lasts", {28'd0, rsp_last_q[rv0+3], rsp_last_q[rv0+2],
                                rsp_last_q[rv0+1], rsp_last_q[rv0]}, 32'h8);
        end
`endif

        // Reset asserted while out_en is high.
        issue_read(16'h0200, 0);
        chk("mid_rd_out_en", {31'd0, out_en}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_out_en", {31'd0, out_en}, 32'd0);
        chk("async_ready", {31'd0, req_ready}, 32'd1);
        chk("async_address", {16'd0, address}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        rv0 = rv_cnt;
        repeat (6) tick();
        chk("no_stale_rsp", rv_cnt - rv0, 32'd0);
        do_read(16'h0200, 0, 0);
        chk("post_rst_data", {16'd0, rsp_data_q[$]}, 32'h585A);

        // Back-to-back alternating write/read with req_valid held high.
        rsp_ready = 1'b1;
        lc0 = ovl_cnt;
        rv0 = rsp_data_q.size();
        for (int i = 0; i < 6; i++) begin
            logic rr;
            int   t;
            req_write = (i % 2 == 0);
            req_addr  = 16'h3000 + 16'((i / 2) % 2);
            req_wdata = 16'h1111 * 16'(i / 2 + 1);
            req_valid = 1'b1;
            t = 0;
            rr = 1'b0;
            while (!rr && t < 40) begin
                @(negedge clk);
                rr = req_ready;
                tick();
                t++;
            end
            chk("b2b_accept", {31'd0, rr}, 32'd1);
        end
        req_valid = 1'b0;
        repeat (8) tick();
        rsp_ready = 1'b0;
        chk("b2b_overlap", ovl_cnt - lc0, 32'd0);
        chk("b2b_rsps", rsp_data_q.size() - rv0, 32'd3);
        if (rsp_data_q.size() - rv0 == 3) begin
            chk("b2b_d0", {16'd0, rsp_data_q[rv0]},   32'h1111);
            chk("b2b_d1", {16'd0, rsp_data_q[rv0+1]}, 32'h2222);
            chk("b2b_d2", {16'd0, rsp_data_q[rv0+2]}, 32'h3333);
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
